spi_frame_receiver: RTL and testbench
=====================================

SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

Interface
REQ-001 Parameter BITS_PER_PIXEL, default 16, pixel word width in bits; SHALL be a multiple of 4.
REQ-002 Parameter ADDR_WIDTH, default 10, pixel write-address width per bank.
REQ-003 Parameter PIXELS_PER_FRAME, default 1024, pixels per complete frame; SHALL be ≤ 2**ADDR_WIDTH.
REQ-004 clk  in  1  system clock; SHALL run at least 4x the spi_clk frequency.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 spi_clk  in  1  SPI clock, asynchronous to clk, mode 0 (sample on rising edge).
REQ-007 spi_mosi  in  1  SPI data, MSB of each pixel first.
REQ-008 spi_ss  in  1  SPI select, active-low; high means idle.
REQ-009 wr_en  out  1  one-clk pulse when a complete pixel is to be written to the frame RAM.
REQ-010 wr_addr  out  ADDR_WIDTH  pixel address for the pulse, valid while wr_en is high.
REQ-011 wr_data  out  BITS_PER_PIXEL  pixel word, valid while wr_en is high.
REQ-012 wr_bank  out  1  bank being filled; the display side SHALL read bank ~wr_bank.
REQ-013 frame_done  out  1  one-clk pulse when a full frame is accepted and the banks swap.
REQ-014 frame_error  out  1  one-clk pulse when a frame ends short, long or mid-word; banks do not swap.

Function
REQ-015 spi_clk, spi_mosi and spi_ss SHALL each pass through a 2-flop synchronizer into clk.
REQ-016 A third register on synchronized spi_clk SHALL give a single-cycle rising-edge strobe.
REQ-017 FSM states SHALL be WAIT_IDLE, IDLE, SHIFT and FRAME_END; the reset state is WAIT_IDLE.
REQ-018 WAIT_IDLE -> IDLE when synchronized spi_ss is high; this prevents entering mid-frame after reset.
REQ-019 IDLE -> SHIFT on synchronized spi_ss low; bit_cnt and pixel_cnt SHALL clear to 0.
REQ-020 In SHIFT, each edge strobe SHALL shift synchronized spi_mosi into the LSB of the shift register and increment bit_cnt.
REQ-021 On the strobe that completes bit BITS_PER_PIXEL-1, wr_en SHALL pulse the next clk with wr_data = completed word and wr_addr = pixel_cnt; pixel_cnt then increments and bit_cnt returns to 0.
REQ-022 Pixels arriving when pixel_cnt == PIXELS_PER_FRAME SHALL NOT produce wr_en and SHALL set an internal overrun flag; pixel_cnt saturates and does not wrap.
REQ-023 SHIFT -> FRAME_END on synchronized spi_ss high; an edge strobe in the same cycle SHALL be processed first.
REQ-024 FRAME_END, when pixel_cnt == PIXELS_PER_FRAME, bit_cnt == 0 and no overrun: pulse frame_done and toggle wr_bank in the same cycle.
REQ-025 FRAME_END, otherwise: pulse frame_error and leave wr_bank unchanged; the next frame rewrites the same bank from address 0.
REQ-026 FRAME_END SHALL always go to IDLE after one cycle and clear the overrun flag.
REQ-027 Edge strobes in WAIT_IDLE, IDLE or FRAME_END SHALL be ignored.
REQ-028 wr_en, frame_done and frame_error SHALL never be high for more than one consecutive clk, and never together.
REQ-029 Latency SHALL be exactly 4 clk rising edges from spi_clk high captured in sync stage 1 to wr_en high, for the final bit of a pixel.

Reset
REQ-030 On reset, all of the following SHALL clear asynchronously to 0: wr_en, wr_addr, wr_data, wr_bank, frame_done, frame_error, counters, shift register, overrun flag and synchronizer flops, and the FSM SHALL enter WAIT_IDLE.
REQ-031 When reset is asserted mid-frame, the partial frame SHALL be discarded; no wr_en, frame_done or frame_error is emitted for it.

Verification
REQ-032 Use PIXELS_PER_FRAME=4 and BITS_PER_PIXEL=16. Send 4 words 0xF00F, 0x1234, 0xABCD, 0x8001 under one spi_ss low period -> 4 wr_en pulses at addr 0..3 with those values, then frame_done pulse and wr_bank 0->1.
REQ-033 Send 3 words then raise spi_ss -> 3 wr_en pulses, then a frame_error pulse, and wr_bank unchanged.
REQ-034 Send 4 words plus 8 extra bits -> 4 wr_en pulses, then frame_error, and no bank toggle; a following good frame -> writes from addr 0 and frame_done.
REQ-035 Send 5 words -> exactly 4 wr_en pulses, then frame_error.
REQ-036 Assert reset after 2 words with spi_ss still low, release it, and continue clocking -> no outputs until spi_ss goes high then low; the next good frame -> frame_done.
REQ-037 Run spi_clk at exactly clk/4 with random phase -> every bit is captured, and the REQ-029 latency is checked on each pixel.

Source files
------------

// File: rtl/spi_frame_receiver.sv
// SPI (mode 0) pixel stream receiver that writes completed pixel words into a
// double-buffered frame RAM and swaps banks only after a complete, well-formed frame.
module spi_frame_receiver #(
   parameter int BITS_PER_PIXEL   = 16,
   parameter int ADDR_WIDTH       = 10,
   parameter int PIXELS_PER_FRAME = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      spi_clk,
   input  logic                      spi_mosi,
   input  logic                      spi_ss,
   output logic                      wr_en,
   output logic [ADDR_WIDTH-1:0]     wr_addr,
   output logic [BITS_PER_PIXEL-1:0] wr_data,
   output logic                      wr_bank,
   output logic                      frame_done,
   output logic                      frame_error
);
   localparam int BIT_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
   localparam int PIX_W = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, FRAME_END} state_t;

   logic sclk_s1_reg, sclk_s2_reg, sclk_s3_reg;
   logic mosi_s1_reg, mosi_s2_reg;
   logic ss_s1_reg, ss_s2_reg;
   logic strobe_reg, mosi_d_reg, ss_d_reg;
   logic edge_strobe;

   state_t                    state_reg, state_next;
   logic [BIT_W-1:0]          bit_cnt_reg, bit_cnt_next;
   logic [PIX_W-1:0]          pixel_cnt_reg, pixel_cnt_next;
   logic [BITS_PER_PIXEL-1:0] shift_reg, shift_next;
   logic                      overrun_reg, overrun_next;
   logic                      wr_en_reg, wr_en_next;
   logic [ADDR_WIDTH-1:0]     wr_addr_reg, wr_addr_next;
   logic [BITS_PER_PIXEL-1:0] wr_data_reg, wr_data_next;
   logic                      wr_bank_reg, wr_bank_next;
   logic                      frame_done_reg, frame_done_next;
   logic                      frame_error_reg, frame_error_next;
   logic [BITS_PER_PIXEL-1:0] shifted_word;

   assign edge_strobe  = sclk_s2_reg & ~sclk_s3_reg;
   assign shifted_word = {shift_reg[BITS_PER_PIXEL-2:0], mosi_d_reg};

   // Strobe, data and select are retimed together so an edge coincident with
   // the select rising is still seen while the FSM is in SHIFT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_s1_reg <= 1'b0;
         sclk_s2_reg <= 1'b0;
         sclk_s3_reg <= 1'b0;
         mosi_s1_reg <= 1'b0;
         mosi_s2_reg <= 1'b0;
         ss_s1_reg   <= 1'b0;
         ss_s2_reg   <= 1'b0;
         strobe_reg  <= 1'b0;
         mosi_d_reg  <= 1'b0;
         ss_d_reg    <= 1'b0;
      end else begin
         sclk_s1_reg <= spi_clk;
         sclk_s2_reg <= sclk_s1_reg;
         sclk_s3_reg <= sclk_s2_reg;
         mosi_s1_reg <= spi_mosi;
         mosi_s2_reg <= mosi_s1_reg;
         ss_s1_reg   <= spi_ss;
         ss_s2_reg   <= ss_s1_reg;
         strobe_reg  <= edge_strobe;
         mosi_d_reg  <= mosi_s2_reg;
         ss_d_reg    <= ss_s2_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= WAIT_IDLE;
         bit_cnt_reg     <= '0;
         pixel_cnt_reg   <= '0;
         shift_reg       <= '0;
         overrun_reg     <= 1'b0;
         wr_en_reg       <= 1'b0;
         wr_addr_reg     <= '0;
         wr_data_reg     <= '0;
         wr_bank_reg     <= 1'b0;
         frame_done_reg  <= 1'b0;
         frame_error_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         bit_cnt_reg     <= bit_cnt_next;
         pixel_cnt_reg   <= pixel_cnt_next;
         shift_reg       <= shift_next;
         overrun_reg     <= overrun_next;
         wr_en_reg       <= wr_en_next;
         wr_addr_reg     <= wr_addr_next;
         wr_data_reg     <= wr_data_next;
         wr_bank_reg     <= wr_bank_next;
         frame_done_reg  <= frame_done_next;
         frame_error_reg <= frame_error_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      bit_cnt_next     = bit_cnt_reg;
      pixel_cnt_next   = pixel_cnt_reg;
      shift_next       = shift_reg;
      overrun_next     = overrun_reg;
      wr_en_next       = 1'b0;
      wr_addr_next     = wr_addr_reg;
      wr_data_next     = wr_data_reg;
      wr_bank_next     = wr_bank_reg;
      frame_done_next  = 1'b0;
      frame_error_next = 1'b0;
      case (state_reg)
         WAIT_IDLE: begin
            if (ss_d_reg) state_next = IDLE;
         end
         IDLE: begin
            if (!ss_d_reg) begin
               state_next     = SHIFT;
               bit_cnt_next   = '0;
               pixel_cnt_next = '0;
            end
         end
         SHIFT: begin
            if (strobe_reg) begin
               shift_next = shifted_word;
               if (bit_cnt_reg == BIT_W'(BITS_PER_PIXEL - 1)) begin
                  bit_cnt_next = '0;
                  // A full frame saturates the pixel count; extra pixels are dropped.
                  if (pixel_cnt_reg == PIX_W'(PIXELS_PER_FRAME)) begin
                     overrun_next = 1'b1;
                  end else begin
                     wr_en_next     = 1'b1;
                     wr_addr_next   = pixel_cnt_reg[ADDR_WIDTH-1:0];
                     wr_data_next   = shifted_word;
                     pixel_cnt_next = pixel_cnt_reg + PIX_W'(1);
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + BIT_W'(1);
               end
            end
            if (ss_d_reg) state_next = FRAME_END;
         end
         FRAME_END: begin
            if (pixel_cnt_reg == PIX_W'(PIXELS_PER_FRAME) && bit_cnt_reg == '0 && !overrun_reg) begin
               frame_done_next = 1'b1;
               wr_bank_next    = ~wr_bank_reg;
            end else begin
               frame_error_next = 1'b1;
            end
            overrun_next = 1'b0;
            state_next   = IDLE;
         end
         default: state_next = WAIT_IDLE;
      endcase
   end

   assign wr_en       = wr_en_reg;
   assign wr_addr     = wr_addr_reg;
   assign wr_data     = wr_data_reg;
   assign wr_bank     = wr_bank_reg;
   assign frame_done  = frame_done_reg;
   assign frame_error = frame_error_reg;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver: 4-pixel frames of 16-bit words,
// spi_clk at clk/4, expected writes/frame events queued by the driver.
module tb_spi_frame_receiver;
   localparam int BPP = 16;
   localparam int AW  = 10;
   localparam int PPF = 4;
   localparam int K_WR   = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   typedef struct {
      int          kind;
      int          addr;
      logic [15:0] data;
      logic        bank;
   } evt_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          spi_clk = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          spi_ss = 1'b1;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [BPP-1:0] wr_data;
   logic          wr_bank;
   logic          frame_done;
   logic          frame_error;

   evt_t   sb_q[$];
   longint lat_q[$];
   int     tests = 0;
   int     failures = 0;
   logic   exp_bank = 1'b0;
   int     exp_addr = 0;
   logic [15:0] frame_words[0:7];

   spi_frame_receiver #(
      .BITS_PER_PIXEL(BPP),
      .ADDR_WIDTH(AW),
      .PIXELS_PER_FRAME(PPF)
   ) dut (
      .clk(clk),
      .reset(reset),
      .spi_clk(spi_clk),
      .spi_mosi(spi_mosi),
      .spi_ss(spi_ss),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_bank(wr_bank),
      .frame_done(frame_done),
      .frame_error(frame_error)
   );

   // Posedges at 5, 15, 25, ...
   initial forever #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic align_phase(input int phase);
      longint now;
      now = longint'($time);
      #((longint'(phase) + 10 - (now % 10)) % 10);
   endtask

   // Sends the top n bits of w, MSB first; a full word may be expected as a write.
   task automatic send_bits(input logic [15:0] w, input int n, input bit exp_wr);
      longint tr;
      evt_t   e;
      if (n == 16 && exp_wr) begin
         e.kind = K_WR; e.addr = exp_addr; e.data = w; e.bank = exp_bank;
         sb_q.push_back(e);
         exp_addr++;
      end
      for (int i = 15; i > 15 - n; i--) begin
         spi_mosi = w[i];
         #20 spi_clk = 1'b1;
         if (i == 0 && exp_wr) begin
            tr = longint'($time);
            // wr_en rises on the 4th clk edge counting the capture edge.
            lat_q.push_back(((tr + 5) / 10) * 10 + 5 + 30 + 1);
         end
         #20 spi_clk = 1'b0;
      end
   endtask

   task automatic run_frame(input int nwords, input int extra_bits, input int phase);
      evt_t e;
      bit   good;
      align_phase(phase);
      spi_ss = 1'b0;
      exp_addr = 0;
      #40;
      for (int k = 0; k < nwords; k++) send_bits(frame_words[k], 16, k < PPF);
      if (extra_bits > 0) send_bits(frame_words[nwords], extra_bits, 1'b0);
      #20;
      good = (nwords == PPF) && (extra_bits == 0);
      e.kind = good ? K_DONE : K_ERR; e.addr = 0; e.data = '0;
      e.bank = good ? ~exp_bank : exp_bank;
      sb_q.push_back(e);
      if (good) exp_bank = ~exp_bank;
      spi_ss = 1'b1;
      #120;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_wr_bank"}, wr_bank, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_frame_error"}, frame_error, 0);
   endtask

   // Monitor: pops one expected event per DUT output pulse.
   initial begin
      evt_t e;
      int   act_kind;
      logic prev_any;
      prev_any = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (wr_en || frame_done || frame_error) begin
            check("one_hot", int'(wr_en) + int'(frame_done) + int'(frame_error), 1);
            check("pulse_width", prev_any, 0);
            act_kind = wr_en ? K_WR : (frame_done ? K_DONE : K_ERR);
            $display("[TB] t=%0t kind=%0d addr=%0d data=%04h bank=%0b", $time, act_kind, wr_addr, wr_data, wr_bank);
            tests++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output: got kind=%0d addr=%0d data=%04h, expected no output", act_kind, wr_addr, wr_data);
            end else begin
               e = sb_q.pop_front();
               check("event_kind", act_kind, e.kind);
               check("wr_bank", wr_bank, e.bank);
               if (wr_en) begin
                  check("wr_addr", wr_addr, e.addr);
                  check("wr_data", wr_data, e.data);
                  if (lat_q.size() > 0) check("latency_time", longint'($time), lat_q.pop_front());
               end
            end
         end
         prev_any = wr_en | frame_done | frame_error;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_words[0] = 16'hF00F; frame_words[1] = 16'h1234;
      frame_words[2] = 16'hABCD; frame_words[3] = 16'h8001;
      frame_words[4] = 16'h5A5A; frame_words[5] = 16'h0F0F;
      frame_words[6] = 16'h0000; frame_words[7] = 16'h0000;

      #23 check_reset_outputs("reset");
      reset = 1'b0;
      #60;

      // Good frame: bank 0 -> 1
      run_frame(4, 0, 2);

      // Reset mid-frame after 2 words, keep clocking with select low
      align_phase(7);
      spi_ss = 1'b0;
      exp_addr = 0;
      #40;
      send_bits(frame_words[0], 16, 1'b1);
      send_bits(frame_words[1], 16, 1'b1);
      #60;
      reset = 1'b1;
      exp_bank = 1'b0;
      #12 check_reset_outputs("midreset");
      check("midreset_sb_drained", sb_q.size(), 0);
      reset = 1'b0;
      send_bits(frame_words[2], 16, 1'b0);
      send_bits(frame_words[3], 16, 1'b0);
      #20 spi_ss = 1'b1;
      #120;
      run_frame(4, 0, 3);

      // Short frame, long by 8 bits then recovery, 5-word overrun
      run_frame(3, 0, 1);
      run_frame(4, 8, 8);
      run_frame(4, 0, 4);
      run_frame(5, 0, 6);

      // Random-phase frames with random pixel data
      for (int f = 0; f < 3; f++) begin
         int ph;
         for (int k = 0; k < 4; k++) frame_words[k] = 16'($urandom);
         ph = $urandom_range(0, 9);
         if (ph == 5) ph = 6;
         run_frame(4, 0, ph);
      end

      #200;
      check("final_sb_empty", sb_q.size(), 0);
      check("final_latency_q_empty", lat_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
